// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if
//   Handshake/bus bundle between a frame producer and serial_pattern_tx.
//   master: the producer (drives load/data/len, observes the rest).
//   slave : the transmitter (serial_pattern_tx).
// Signals
//   load     frame request, sampled only while ready=1
//   data     frame bits, only [len-1:0] are used
//   len      frame length in bits, legal 1..WIDTH
//   ready    a load is accepted at this edge
//   x        serial bit, 0 when not transmitting
//   xvalid   x carries a frame bit
//   done     one-cycle pulse in the cycle after the last bit
//   pair_cnt number of adjacent (0,1) pairs in the last completed frame
//   err      one-cycle pulse after a load with an illegal len
interface serial_pattern_tx_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
);
   logic             load;
   logic [WIDTH-1:0] data;
   logic [CNT_W-1:0] len;
   logic             ready;
   logic             x;
   logic             xvalid;
   logic             done;
   logic [CNT_W-1:0] pair_cnt;
   logic             err;

   modport master (
      output load, data, len,
      input  ready, x, xvalid, done, pair_cnt, err
   );

   modport slave (
      input  load, data, len,
      output ready, x, xvalid, done, pair_cnt, err
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial stimulus transmitter for the x/z sequence-detector family.
//   A parallel frame is taken through a load/ready handshake and shifted
//   out one bit per clock on x, qualified by xvalid. The number of
//   adjacent (0,1) pairs emitted in each frame is reported on pair_cnt
//   when the frame completes, for comparison against a detector's z pulses.
// Ports
//   clk  rising-edge clock
//   rst  synchronous reset, active-high, overrides everything
//   bus  serial_pattern_tx_if.slave (load, data, len, ready, x, xvalid,
//        done, pair_cnt, err)
// Parameters
//   WIDTH  maximum frame length (2..64); CNT_W width of len/pair_cnt,
//          2**CNT_W must exceed WIDTH
// Configuration
//   SERIAL_TX_MSB_FIRST_EN  defined: frame sent data[len-1] first.
//                           undefined (default): data[0] first.
// Timing
//   Accept at edge N puts bit k on x in cycle N+1+k; done and the new
//   pair_cnt appear in cycle N+len+1. All outputs are registered.
module serial_pattern_tx #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic clk,
   input  logic rst,
   serial_pattern_tx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shreg;      // bits still to be sent, next bit at the exit end
   logic [CNT_W-1:0] remain;     // bits left after the one currently on x
   logic             prev_bit;   // bit currently on x, for pair detection
   logic [CNT_W-1:0] pair_acc;   // running pair count of the frame in flight

   logic             ready_r;
   logic             x_r;
   logic             xvalid_r;
   logic             done_r;
   logic [CNT_W-1:0] pair_cnt_r;
   logic             err_r;

   logic             len_ok;
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] shreg_load;
   logic [WIDTH-1:0] shreg_next;

   assign len_ok = (bus.len != '0) && (bus.len <= WIDTH_C);

`ifdef SERIAL_TX_MSB_FIRST_EN
   // Left-align the frame so data[len-1] sits at the MSB, then shift left.
   logic [WIDTH-1:0] load_img;

   always_comb begin
      load_img   = bus.data << (WIDTH_C - bus.len);
      first_bit  = load_img[WIDTH-1];
      shreg_load = load_img << 1;
      next_bit   = shreg[WIDTH-1];
      shreg_next = shreg << 1;
   end
`else
   // Bits above len-1 are never reached because the bit counter stops first.
   always_comb begin
      first_bit  = bus.data[0];
      shreg_load = bus.data >> 1;
      next_bit   = shreg[0];
      shreg_next = shreg >> 1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ready_r    <= 1'b1;
         x_r        <= 1'b0;
         xvalid_r   <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         pair_cnt_r <= '0;
         pair_acc   <= '0;
         prev_bit   <= 1'b0;
         remain     <= '0;
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.load && len_ok) begin
                  // Accept: first bit goes straight onto x for 1-cycle latency.
                  state    <= SHIFT;
                  ready_r  <= 1'b0;
                  x_r      <= first_bit;
                  xvalid_r <= 1'b1;
                  shreg    <= shreg_load;
                  remain   <= bus.len - CNT_W'(1);
                  prev_bit <= first_bit;
                  pair_acc <= '0;
               end else begin
                  // Illegal len is dropped; a DONE cycle still falls to IDLE.
                  err_r    <= bus.load;
                  state    <= IDLE;
                  ready_r  <= 1'b1;
                  x_r      <= 1'b0;
                  xvalid_r <= 1'b0;
               end
            end
            SHIFT: begin
               if (remain == '0) begin
                  state      <= DONE;
                  ready_r    <= 1'b1;
                  x_r        <= 1'b0;
                  xvalid_r   <= 1'b0;
                  done_r     <= 1'b1;
                  pair_cnt_r <= pair_acc;
               end else begin
                  x_r      <= next_bit;
                  shreg    <= shreg_next;
                  remain   <= remain - CNT_W'(1);
                  prev_bit <= next_bit;
                  // The first bit of a frame is loaded as prev_bit, so it can
                  // only ever be the 0 side of a pair.
                  if (!prev_bit && next_bit) begin
                     pair_acc <= pair_acc + CNT_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               ready_r  <= 1'b1;
               x_r      <= 1'b0;
               xvalid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready    = ready_r;
   assign bus.x        = x_r;
   assign bus.xvalid   = xvalid_r;
   assign bus.done     = done_r;
   assign bus.pair_cnt = pair_cnt_r;
   assign bus.err      = err_r;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx
//   Directed bench for serial_pattern_tx (WIDTH=16, CNT_W=5). Inputs are
//   driven 1 time unit after each rising edge and outputs are observed at
//   the same point, so each observation reflects the edge just taken.
module tb_serial_pattern_tx;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   logic clk;
   logic rst;

   int tests = 0;
   int fails = 0;

   serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-derived transmit orders.
   // 16'h0012, len 5 : data bits [4:0] = 1,0,0,1,0 (b4..b0)
   // 14'b00110111000100 : b13..b0 = 0,0,1,1,0,1,1,1,0,0,0,1,0,0
`ifdef SERIAL_TX_MSB_FIRST_EN
   logic f5  [5]  = '{1, 0, 0, 1, 0};
   logic f14 [14] = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
   localparam int PAIRS5 = 1;
`else
   logic f5  [5]  = '{0, 1, 0, 0, 1};
   logic f14 [14] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
   localparam int PAIRS5 = 2;
`endif
   localparam int PAIRS14 = 3;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ready"},  64'(bus.ready),  64'd1);
      chk({tag, ".x"},      64'(bus.x),      64'd0);
      chk({tag, ".xvalid"}, 64'(bus.xvalid), 64'd0);
      chk({tag, ".done"},   64'(bus.done),   64'd0);
      chk({tag, ".err"},    64'(bus.err),    64'd0);
   endtask

   initial begin
      // Reset held 3 cycles with a legal load pending: nothing may start.
      rst      = 1'b1;
      bus.load = 1'b1;
      bus.data = 16'h0012;
      bus.len  = 5'd5;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle("reset");
         chk("reset.pair_cnt", 64'(bus.pair_cnt), 64'd0);
      end
      rst      = 1'b0;
      bus.load = 1'b0;
      step();
      chk_idle("post_reset");

      // 5-bit frame 16'h0012.
      bus.load = 1'b1;
      bus.data = 16'h0012;
      bus.len  = 5'd5;
      step();
      bus.load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("f5.x",      64'(bus.x),      64'(f5[k]));
         chk("f5.xvalid", 64'(bus.xvalid), 64'd1);
         chk("f5.ready",  64'(bus.ready),  64'd0);
         step();
      end
      chk("f5.done",     64'(bus.done),     64'd1);
      chk("f5.xvalid_d", 64'(bus.xvalid),   64'd0);
      chk("f5.ready_d",  64'(bus.ready),    64'd1);
      chk("f5.pair_cnt", 64'(bus.pair_cnt), 64'(PAIRS5));
      step();
      chk_idle("f5.idle");
      chk("f5.pair_hold", 64'(bus.pair_cnt), 64'(PAIRS5));

      // 14-bit frame, then a second frame accepted in its DONE cycle.
      bus.load = 1'b1;
      bus.data = 16'h0DC4;
      bus.len  = 5'd14;
      step();
      bus.load = 1'b0;
      for (int k = 0; k < 14; k++) begin
         chk("f14.x",      64'(bus.x),      64'(f14[k]));
         chk("f14.xvalid", 64'(bus.xvalid), 64'd1);
         step();
      end
      chk("f14.done",     64'(bus.done),     64'd1);
      chk("f14.gap",      64'(bus.xvalid),   64'd0);
      chk("f14.pair_cnt", 64'(bus.pair_cnt), 64'(PAIRS14));
      // Frame B: 3'b101 is 1,0,1 in either bit order, one pair.
      bus.load = 1'b1;
      bus.data = 16'h0005;
      bus.len  = 5'd3;
      step();
      bus.load = 1'b0;
      chk("b2b.x0",      64'(bus.x),        64'd1);
      chk("b2b.xvalid0", 64'(bus.xvalid),   64'd1);
      chk("b2b.done0",   64'(bus.done),     64'd0);
      chk("b2b.hold",    64'(bus.pair_cnt), 64'(PAIRS14));
      step();
      chk("b2b.x1",      64'(bus.x),        64'd0);
      step();
      chk("b2b.x2",      64'(bus.x),        64'd1);
      step();
      chk("b2b.done",    64'(bus.done),     64'd1);
      chk("b2b.pair",    64'(bus.pair_cnt), 64'd1);
      step();
      chk_idle("b2b.idle");

      // Illegal lengths 0 and 17.
      bus.load = 1'b1;
      bus.len  = 5'd0;
      step();
      chk("len0.err",    64'(bus.err),    64'd1);
      chk("len0.xvalid", 64'(bus.xvalid), 64'd0);
      chk("len0.ready",  64'(bus.ready),  64'd1);
      bus.load = 1'b0;
      step();
      chk_idle("len0.after");
      bus.load = 1'b1;
      bus.len  = 5'd17;
      step();
      chk("len17.err",    64'(bus.err),    64'd1);
      chk("len17.xvalid", 64'(bus.xvalid), 64'd0);
      chk("len17.ready",  64'(bus.ready),  64'd1);
      bus.load = 1'b0;
      step();
      chk_idle("len17.after");
      chk("len17.pair_hold", 64'(bus.pair_cnt), 64'd1);

      // len=1: single xvalid cycle, pair_cnt 0.
      bus.load = 1'b1;
      bus.data = 16'h0001;
      bus.len  = 5'd1;
      step();
      bus.load = 1'b0;
      chk("len1.x",      64'(bus.x),        64'd1);
      chk("len1.xvalid", 64'(bus.xvalid),   64'd1);
      step();
      chk("len1.done",   64'(bus.done),     64'd1);
      chk("len1.xv_off", 64'(bus.xvalid),   64'd0);
      chk("len1.pair",   64'(bus.pair_cnt), 64'd0);
      step();

      // Mid-frame load ignored silently, then reset during bit 2.
      bus.load = 1'b1;
      bus.data = 16'h0012;
      bus.len  = 5'd5;
      step();
      chk("abort.x0", 64'(bus.x), 64'(f5[0]));
      bus.len  = 5'd0;
      step();
      bus.load = 1'b0;
      chk("midload.err",    64'(bus.err),    64'd0);
      chk("midload.x1",     64'(bus.x),      64'(f5[1]));
      chk("midload.xvalid", 64'(bus.xvalid), 64'd1);
      step();
      chk("abort.x2", 64'(bus.x), 64'(f5[2]));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("abort");
      chk("abort.pair_cnt", 64'(bus.pair_cnt), 64'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk_idle("abort.quiet");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
